// File: rtl/basys_io_pkg.sv
// ----------------------------------------------------------------------------
// basys_io_pkg
//
// Shared constants for the Basys board I/O blocks.
//   - Register offsets of the input port's 16-byte window.
//   - Default debounce length.
//   - Width of the wrapping press counter.
//   - Register-select enum and a helper that maps a byte offset to it.
// ----------------------------------------------------------------------------
package basys_io_pkg;

    localparam logic [3:0] OFS_SW    = 4'h0;
    localparam logic [3:0] OFS_BTN   = 4'h4;
    localparam logic [3:0] OFS_PRESS = 4'h8;
    localparam logic [3:0] OFS_COUNT = 4'hC;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        SEL_SW    = 2'd0,
        SEL_BTN   = 2'd1,
        SEL_PRESS = 2'd2,
        SEL_COUNT = 2'd3
    } reg_sel_e;

    // Offset bits [1:0] are ignored, so only bits [3:2] pick the register.
    function automatic reg_sel_e offset_to_sel(input logic [3:0] ofs);
        reg_sel_e sel;
        case (ofs & 4'hC)
            OFS_SW:    sel = SEL_SW;
            OFS_BTN:   sel = SEL_BTN;
            OFS_PRESS: sel = SEL_PRESS;
            default:   sel = SEL_COUNT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//
// One raw asynchronous input bit: 2-flop synchronizer followed by a
// stable-level / run-length debouncer.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   din  in   raw asynchronous level
//   dout out  the debounced level that takes effect at the next rising edge
//             (combinational from registered state). Exposing the next level
//             lets the parent register the level, its press edge and the
//             press count on the very same edge the level changes.
//
// A new level is accepted after DEBOUNCE_CYCLES consecutive cycles in which
// the synchronized input differs from the stable level; any cycle in which it
// matches restarts the run.
// ----------------------------------------------------------------------------
module input_debouncer
    import basys_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic        stable;
    logic        stable_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;

    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        if (sync2 != stable) begin
            if (cnt == CNT_LAST) begin
                stable_nxt = ~stable;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign dout = stable_nxt;

endmodule

// File: rtl/basys_input_port.sv
// ----------------------------------------------------------------------------
// basys_input_port
//
// Memory-mapped input port for the Basys switches and push-buttons.
//
// Register window (16 bytes at BASE_ADDR, offset bits [1:0] ignored):
//   0x0 SW     debounced switches, zero-extended
//   0x4 BTN    debounced button levels, zero-extended
//   0x8 PRESS  sticky press flags; a read with ReadEn clears them at the next
//              edge (a press arriving on that same edge still sets its bit)
//   0xC COUNT  16-bit wrapping press count in [15:0]
//
// Bus: ReadEn is a one-cycle read strobe. There is no ready/stall: RData is
// valid combinationally in the same cycle as Adr, and the only side effect
// of a read (PRESS clear) happens at the following rising edge. Hit reflects
// Adr alone; with Hit low, RData is 0 and ReadEn does nothing.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sw, btn    raw asynchronous switch / button levels (active-high)
//   Adr        read byte address
//   ReadEn     read strobe
//   RData      read data
//   Hit        Adr is inside the window
//   Irq        OR of PRESS, registered (only with BASYS_INPUT_IRQ_EN)
//
// Build option: define BASYS_INPUT_IRQ_EN to add the Irq output.
// ----------------------------------------------------------------------------
module basys_input_port
    import basys_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [31:0]        Adr,
    input  logic               ReadEn,
    output logic [31:0]        RData,
    output logic               Hit
`ifdef BASYS_INPUT_IRQ_EN
    ,
    output logic               Irq
`endif
);

    logic [NUM_SW-1:0]  sw_next;
    logic [NUM_SW-1:0]  sw_q;
    logic [NUM_BTN-1:0] btn_next;
    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] press_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] press_add;
    logic [3:0]         ofs;
    reg_sel_e           sel;
    logic               rd_clear;
    logic               unused_adr_lsbs;

    // ---------------- input conditioning ----------------
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (sw[i]),
            .dout (sw_next[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (btn[i]),
            .dout (btn_next[i])
        );
    end

    // A press is the debounced level about to rise at this edge, so BTN,
    // PRESS and COUNT all change together.
    assign press = btn_next & ~btn_q;

    always_comb begin
        press_add = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            press_add = press_add + COUNT_W'(press[i]);
        end
    end

    // ---------------- address decode ----------------
    assign Hit             = (Adr[31:4] == BASE_ADDR[31:4]);
    assign ofs             = {Adr[3:2], 2'b00};
    assign sel             = offset_to_sel(ofs);
    assign rd_clear        = ReadEn && Hit && (sel == SEL_PRESS);
    assign unused_adr_lsbs = ^Adr[1:0];

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q    <= '0;
            btn_q   <= '0;
            press_q <= '0;
            count_q <= '0;
        end else begin
            sw_q    <= sw_next;
            btn_q   <= btn_next;
            // Clear first, then OR in new presses: a press on the clearing
            // edge survives.
            press_q <= (rd_clear ? '0 : press_q) | press;
            count_q <= count_q + press_add;
        end
    end

`ifdef BASYS_INPUT_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            Irq <= 1'b0;
        end else begin
            Irq <= |press_q;
        end
    end
`endif

    // ---------------- read mux ----------------
    always_comb begin
        RData = '0;
        if (Hit) begin
            case (sel)
                SEL_SW:    RData = 32'(sw_q);
                SEL_BTN:   RData = 32'(btn_q);
                SEL_PRESS: RData = 32'(press_q);
                default:   RData = 32'(count_q);
            endcase
        end
    end

endmodule
